// File: rtl/exe_mul_unit.sv
`default_nettype none
// ============================================================================
// Module      : exe_mul_unit
// Description : Iterative radix-2 shift-add 32x32 multiplier for the EXE
//               stage. Produces the 64-bit product for MUL/MULT/MULTU with a
//               fixed 34-cycle turnaround and stalls the pipeline front end
//               while it iterates.
// Revision    : 1.0 - initial release
// ============================================================================
module exe_mul_unit #(
   parameter int ITER = 32
) (
   input  logic        clk,
   input  logic        rst,      // asynchronous, active-low
   input  logic        start,
   input  logic        sign,
   input  logic        flush,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        stall,
   output logic        done,
   output logic [31:0] res_lo,
   output logic [31:0] res_hi
);

   // Counter must hold 0..ITER so the last-iteration compare fits.
   localparam int                c_CNT_W = $clog2(ITER) + 1;
   localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(ITER - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               state_q,  state_d;
   logic [31:0]          mcand_q,  mcand_d;   // |a|, added on each set bit
   logic [31:0]          mplier_q, mplier_d;  // |b|, shifted out LSB first
   logic [32:0]          acc_q,    acc_d;     // upper accumulator, carry kept
   logic [c_CNT_W-1:0]   cnt_q,    cnt_d;
   logic                 neg_q,    neg_d;
   logic                 done_q,   done_d;
   logic [31:0]          res_lo_q, res_lo_d;
   logic [31:0]          res_hi_q, res_hi_d;

   logic [31:0]          w_a_mag;
   logic [31:0]          w_b_mag;
   logic                 w_neg;
   logic                 w_accept;
   logic [32:0]          w_add;
   logic [64:0]          w_shift;
   logic [32:0]          w_acc_nxt;
   logic [31:0]          w_mplier_nxt;
   logic [63:0]          w_prod_mag;
   logic [63:0]          w_prod;

   // Operand conditioning: signed operands are reduced to magnitudes so the
   // core only ever multiplies unsigned values. 0x8000_0000 maps onto itself,
   // which is the correct unsigned magnitude 2^31.
   always_comb begin
      w_a_mag  = (sign && a[31]) ? (~a + 32'd1) : a;
      w_b_mag  = (sign && b[31]) ? (~b + 32'd1) : b;
      w_neg    = sign & (a[31] ^ b[31]);
      w_accept = (state_q == S_IDLE) && start && !flush;
   end

   // One shift-add step: conditionally add the multiplicand into the upper
   // half, then shift the combined {acc, multiplier} right by one.
   always_comb begin
      w_add        = mplier_q[0] ? (acc_q + {1'b0, mcand_q}) : acc_q;
      w_shift      = {w_add, mplier_q} >> 1;
      w_acc_nxt    = w_shift[64:32];
      w_mplier_nxt = w_shift[31:0];
      w_prod_mag   = {w_acc_nxt[31:0], w_mplier_nxt};
      w_prod       = neg_q ? (~w_prod_mag + 64'd1) : w_prod_mag;
   end

   // Next-state and datapath control; flush beats every other action.
   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;
      done_d   = 1'b0;
      res_lo_d = res_lo_q;
      res_hi_d = res_hi_q;

      case (state_q)
         S_IDLE: begin
            if (w_accept) begin
               mcand_d  = w_a_mag;
               mplier_d = w_b_mag;
               neg_d    = w_neg;
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = S_BUSY;
            end
         end

         S_BUSY: begin
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               acc_d    = w_acc_nxt;
               mplier_d = w_mplier_nxt;
               cnt_d    = cnt_q + c_CNT_W'(1);
               if (cnt_q == c_LAST) begin
                  res_lo_d = w_prod[31:0];
                  res_hi_d = w_prod[63:32];
                  done_d   = 1'b1;
                  state_d  = S_DONE;
               end
            end
         end

         // The result is already registered; start still belongs to the
         // completing instruction, so this state never accepts.
         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers, cleared on the asynchronous reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         done_q   <= 1'b0;
         res_lo_q <= '0;
         res_hi_q <= '0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         neg_q    <= neg_d;
         done_q   <= done_d;
         res_lo_q <= res_lo_d;
         res_hi_q <= res_hi_d;
      end
   end

   // Stall is combinational so the front end freezes in the accept cycle;
   // it drops during DONE so EXE/MEM captures res_lo, and drops on flush.
   always_comb begin
      stall = !flush && (((state_q == S_IDLE) && start) || (state_q == S_BUSY));
   end

   assign done   = done_q;
   assign res_lo = res_lo_q;
   assign res_hi = res_hi_q;

endmodule
`default_nettype wire
